// File: rtl/frost32_cpu.sv
// frost32_cpu: 32-bit multicycle RISC core with 16 registers and one shared big-endian memory port.
// Sequence per instruction: FETCH -> FETCH_WAIT -> EXEC (-> MEM_WAIT for loads); HALT is absorbing.
module frost32_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_req_mem_access,
    output logic        out_data_inout_access_type,
    output logic [1:0]  out_data_inout_access_size,
    output logic        out_halted
);

    localparam logic [2:0] ST_FETCH      = 3'd0;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
    localparam logic [2:0] ST_EXEC       = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT   = 3'd3;
    localparam logic [2:0] ST_HALT       = 3'd4;

    localparam logic       DIAT_READ  = 1'b0;
    localparam logic       DIAT_WRITE = 1'b1;
    localparam logic [1:0] DIAS_8     = 2'd0;
    localparam logic [1:0] DIAS_16    = 2'd1;
    localparam logic [1:0] DIAS_32    = 2'd2;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [16];

    logic [3:0]  grp, op, ra_idx, rb_idx, rc_idx;
    logic [15:0] imm;
    logic [31:0] ra_val, rb_val, rc_val;
    logic [31:0] pc_plus4, imm_sext, imm_zext, ea;

    assign grp      = ir[31:28];
    assign op       = ir[27:24];
    assign ra_idx   = ir[23:20];
    assign rb_idx   = ir[19:16];
    assign rc_idx   = ir[15:12];
    assign imm      = ir[15:0];
    // r0 is never written, so its reset value of zero is what every read sees.
    assign ra_val   = regs[ra_idx];
    assign rb_val   = regs[rb_idx];
    assign rc_val   = regs[rc_idx];
    assign pc_plus4 = pc + 32'd4;
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign ea       = rb_val + imm_sext;

    logic        wr_en;
    logic [31:0] wr_val;
    logic [31:0] next_pc;
    logic        do_load, do_store, do_halt;
    logic [1:0]  mem_size;
    logic [31:0] load_val;

    always_comb begin
        wr_en    = 1'b0;
        wr_val   = 32'h0;
        next_pc  = pc_plus4;
        do_load  = 1'b0;
        do_store = 1'b0;
        do_halt  = 1'b0;
        mem_size = DIAS_32;
        case (grp)
            4'h0: begin
                wr_en = 1'b1;
                case (op)
                    4'h0: wr_val = rb_val + rc_val;
                    4'h1: wr_val = rb_val - rc_val;
                    4'h2: wr_val = rb_val & rc_val;
                    4'h3: wr_val = rb_val | rc_val;
                    4'h4: wr_val = rb_val ^ rc_val;
                    4'h5: wr_val = {31'h0, ($signed(rb_val) < $signed(rc_val))};
                    4'h6: wr_val = {31'h0, (rb_val < rc_val)};
                    4'h7: wr_val = rb_val << rc_val[4:0];
                    4'h8: wr_val = rb_val >> rc_val[4:0];
                    4'h9: wr_val = 32'($signed(rb_val) >>> rc_val[4:0]);
                    default: wr_en = 1'b0;
                endcase
            end
            4'h1: begin
                wr_en = 1'b1;
                case (op)
                    4'h0: wr_val = rb_val + imm_sext;
                    4'h1: wr_val = rb_val & imm_zext;
                    4'h2: wr_val = rb_val | imm_zext;
                    4'h3: wr_val = rb_val ^ imm_zext;
                    4'h4: wr_val = {imm, 16'h0000};
                    default: wr_en = 1'b0;
                endcase
            end
            4'h2: begin
                if ((op == 4'h0 && ra_val == rb_val) || (op == 4'h1 && ra_val != rb_val))
                    next_pc = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
            end
            4'h3: begin
                // rb_val is sampled before the link write lands, so rA == rB jumps to the old value.
                if (op == 4'h0) begin
                    wr_en   = 1'b1;
                    wr_val  = pc_plus4;
                    next_pc = rb_val;
                end
            end
            4'h4: begin
                case (op)
                    4'h0: begin do_load  = 1'b1; mem_size = DIAS_32; end
                    4'h1: begin do_load  = 1'b1; mem_size = DIAS_16; end
                    4'h2: begin do_load  = 1'b1; mem_size = DIAS_8;  end
                    4'h3: begin do_store = 1'b1; mem_size = DIAS_32; end
                    4'h4: begin do_store = 1'b1; mem_size = DIAS_16; end
                    4'h5: begin do_store = 1'b1; mem_size = DIAS_8;  end
                    default: ;
                endcase
            end
            4'hF: do_halt = (op == 4'hF);
            default: ;
        endcase
    end

    // Narrow loads are masked here even though memory already returns zero upper bits.
    always_comb begin
        case (op)
            4'h1:    load_val = {16'h0000, in_data[15:0]};
            4'h2:    load_val = {24'h000000, in_data[7:0]};
            default: load_val = in_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                      <= ST_FETCH;
            pc                         <= RESET_PC;
            ir                         <= 32'h0;
            for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
            out_req_mem_access         <= 1'b0;
            out_addr                   <= 32'h0;
            out_data                   <= 32'h0;
            out_data_inout_access_type <= DIAT_READ;
            out_data_inout_access_size <= DIAS_32;
            out_halted                 <= 1'b0;
        end else begin
            out_req_mem_access <= 1'b0;
            case (state)
                ST_FETCH: begin
                    out_req_mem_access         <= 1'b1;
                    out_addr                   <= pc;
                    out_data_inout_access_type <= DIAT_READ;
                    out_data_inout_access_size <= DIAS_32;
                    state                      <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    ir    <= in_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (do_halt) begin
                        out_halted <= 1'b1;
                        state      <= ST_HALT;
                    end else begin
                        pc <= next_pc;
                        if (wr_en && ra_idx != 4'h0) regs[ra_idx] <= wr_val;
                        if (do_load || do_store) begin
                            out_req_mem_access         <= 1'b1;
                            out_addr                   <= ea;
                            out_data                   <= ra_val;
                            out_data_inout_access_type <= do_store ? DIAT_WRITE : DIAT_READ;
                            out_data_inout_access_size <= mem_size;
                        end
                        state <= do_load ? ST_MEM_WAIT : ST_FETCH;
                    end
                end
                ST_MEM_WAIT: begin
                    if (ra_idx != 4'h0) regs[ra_idx] <= load_val;
                    state <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_cpu.sv
// Directed bench for frost32_cpu: small programs run against a big-endian byte memory model,
// results read back from memory and timing checked against hand-computed cycle counts.
module tb_frost32_cpu;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_req_mem_access;
    logic        out_data_inout_access_type;
    logic [1:0]  out_data_inout_access_size;
    logic        out_halted;

    frost32_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .in_data                    (in_data),
        .out_data                   (out_data),
        .out_addr                   (out_addr),
        .out_req_mem_access         (out_req_mem_access),
        .out_data_inout_access_type (out_data_inout_access_type),
        .out_data_inout_access_size (out_data_inout_access_size),
        .out_halted                 (out_halted)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int req_cnt = 0;
    int req_snap;
    int prog_sel = 0;
    logic load_img = 1'b0;
    logic [7:0] mem [1024];

    function automatic logic [31:0] ei(input logic [3:0] g, o, a, b, input logic [15:0] im);
        return {g, o, a, b, im};
    endfunction

    function automatic logic [31:0] rr(input logic [3:0] g, o, a, b, c);
        return {g, o, a, b, c, 12'h000};
    endfunction

    localparam logic [31:0] HALT_W = 32'hFF00_0000;

    function automatic logic [31:0] img_word(input int p, input int w);
        logic [31:0] r;
        r = 32'h0;
        case (p)
            1: case (w)
                0: r = ei(1, 0, 1, 0, 16'h0005);
                1: r = ei(1, 0, 2, 0, 16'hFFFD);
                2: r = rr(0, 0, 3, 1, 2);
                3: r = ei(4, 3, 3, 0, 16'h0100);
                4: r = HALT_W;
                default: ;
            endcase
            2: case (w)
                0:  r = ei(4, 0, 1, 0, 16'h0200);
                1:  r = ei(4, 1, 2, 0, 16'h0200);
                2:  r = ei(4, 2, 3, 0, 16'h0203);
                3:  r = ei(4, 3, 1, 0, 16'h0300);
                4:  r = ei(4, 3, 2, 0, 16'h0304);
                5:  r = ei(4, 3, 3, 0, 16'h0308);
                6:  r = ei(1, 4, 4, 0, 16'h1122);
                7:  r = ei(1, 2, 4, 4, 16'h3344);
                8:  r = ei(4, 5, 4, 0, 16'h0201);
                9:  r = ei(4, 4, 4, 0, 16'h0310);
                10: r = HALT_W;
                128: r = 32'hDEAD_BEEF;
                default: ;
            endcase
            3: case (w)
                0:  r = ei(1, 0, 1, 0, 16'h0003);
                1:  r = ei(1, 0, 1, 1, 16'hFFFF);
                2:  r = ei(1, 0, 2, 2, 16'h0001);
                3:  r = ei(2, 1, 1, 0, 16'hFFFD);
                4:  r = ei(4, 3, 2, 0, 16'h0100);
                5:  r = ei(1, 0, 0, 0, 16'h0007);
                6:  r = ei(4, 3, 0, 0, 16'h0104);
                7:  r = ei(1, 0, 6, 0, 16'h0040);
                8:  r = ei(3, 0, 5, 6, 16'h0000);
                9:  r = HALT_W;
                16: r = ei(4, 3, 5, 0, 16'h0108);
                17: r = ei(1, 0, 9, 0, 16'h0001);
                18: r = rr(0, 1, 8, 0, 9);
                19: r = rr(0, 6, 10, 8, 9);
                20: r = rr(0, 5, 11, 8, 9);
                21: r = ei(4, 3, 8, 0, 16'h010C);
                22: r = ei(4, 3, 10, 0, 16'h0110);
                23: r = ei(4, 3, 11, 0, 16'h0114);
                24: r = rr(0, 8, 14, 8, 9);
                25: r = ei(4, 3, 14, 0, 16'h0118);
                26: r = HALT_W;
                65: r = 32'hAAAA_AAAA;
                68: r = 32'hAAAA_AAAA;
                default: ;
            endcase
            4: case (w)
                0:  r = ei(2, 1, 1, 0, 16'h001F);
                1:  r = ei(1, 0, 1, 0, 16'h0009);
                2:  r = ei(4, 0, 2, 0, 16'h0200);
                3:  r = ei(4, 3, 1, 0, 16'h0100);
                4:  r = ei(4, 3, 2, 0, 16'h0108);
                5:  r = HALT_W;
                32: r = ei(4, 3, 1, 0, 16'h0104);
                33: r = HALT_W;
                128: r = 32'hDEAD_BEEF;
                default: ;
            endcase
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] img_byte(input int p, input int a);
        logic [31:0] w;
        w = img_word(p, a / 4);
        return w[31 - 8 * (a % 4) -: 8];
    endfunction

    // Memory model: samples requests on the mid-cycle full-rate edge (core clk negedge).
    always @(negedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 1024; i++) mem[i] <= img_byte(prog_sel, i);
        end else if (out_req_mem_access) begin
            req_cnt <= req_cnt + 1;
            if (out_data_inout_access_type) begin
                case (out_data_inout_access_size)
                    2'd0: mem[out_addr[9:0]] <= out_data[7:0];
                    2'd1: begin
                        mem[out_addr[9:0]]          <= out_data[15:8];
                        mem[10'(out_addr[9:0] + 1)] <= out_data[7:0];
                    end
                    default: begin
                        mem[out_addr[9:0]]          <= out_data[31:24];
                        mem[10'(out_addr[9:0] + 1)] <= out_data[23:16];
                        mem[10'(out_addr[9:0] + 2)] <= out_data[15:8];
                        mem[10'(out_addr[9:0] + 3)] <= out_data[7:0];
                    end
                endcase
            end else begin
                case (out_data_inout_access_size)
                    2'd0: in_data <= {24'h0, mem[out_addr[9:0]]};
                    2'd1: in_data <= {16'h0, mem[out_addr[9:0]], mem[10'(out_addr[9:0] + 1)]};
                    default: in_data <= {mem[out_addr[9:0]], mem[10'(out_addr[9:0] + 1)],
                                         mem[10'(out_addr[9:0] + 2)], mem[10'(out_addr[9:0] + 3)]};
                endcase
            end
        end
    end

    function automatic logic [31:0] rd32(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    // driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic reset_and_load(input int p);
        rst_n = 1'b0;
        prog_sel = p;
        @(posedge clk);
        load_img = 1'b1;
        @(negedge clk);
        #1 load_img = 1'b0;
    endtask

    task automatic start_core(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        check({tag, "_first_req"},  32'(out_req_mem_access), 32'd1);
        check({tag, "_first_addr"}, out_addr, 32'h0);
        check({tag, "_first_type"}, 32'(out_data_inout_access_type), 32'd0);
        check({tag, "_first_size"}, 32'(out_data_inout_access_size), 32'd2);
    endtask

    task automatic run_to_halt(input string tag, input int exp_cyc);
        while (!out_halted && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_halt_cycle"}, 32'(cyc), 32'(exp_cyc));
        req_snap = req_cnt;
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_halted_stays"}, 32'(out_halted), 32'd1);
        check({tag, "_no_req_after_halt"}, 32'(req_cnt - req_snap), 32'd0);
    endtask

    // directed sequence and scoreboard
    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req",    32'(out_req_mem_access), 32'd0);
        check("rst_addr",   out_addr, 32'h0);
        check("rst_data",   out_data, 32'h0);
        check("rst_type",   32'(out_data_inout_access_type), 32'd0);
        check("rst_size",   32'(out_data_inout_access_size), 32'd2);
        check("rst_halted", 32'(out_halted), 32'd0);

        // addi / addi / add / st32 / halt
        reset_and_load(1);
        check("p1_req_in_reset", 32'(out_req_mem_access), 32'd0);
        start_core("p1");
        run_to_halt("p1", 15);
        check("p1_mem100", rd32(32'h100), 32'h0000_0002);

        // loads and narrow stores
        reset_and_load(2);
        start_core("p2");
        run_to_halt("p2", 36);
        check("p2_ld32",  rd32(32'h300), 32'hDEAD_BEEF);
        check("p2_ldu16", rd32(32'h304), 32'h0000_DEAD);
        check("p2_ldu8",  rd32(32'h308), 32'h0000_00EF);
        check("p2_st8",   rd32(32'h200), 32'hDE44_BEEF);
        check("p2_st16",  rd32(32'h310), 32'h3344_0000);

        // loop, r0 write, jal, sub/sltu/slt/lsr
        reset_and_load(3);
        start_core("p3");
        run_to_halt("p3", 78);
        check("p3_loop_count", rd32(32'h100), 32'h0000_0003);
        check("p3_r0_store",   rd32(32'h104), 32'h0000_0000);
        check("p3_jal_link",   rd32(32'h108), 32'h0000_0024);
        check("p3_sub",        rd32(32'h10C), 32'hFFFF_FFFF);
        check("p3_sltu",       rd32(32'h110), 32'h0000_0000);
        check("p3_slt",        rd32(32'h114), 32'h0000_0001);
        check("p3_lsr",        rd32(32'h118), 32'h7FFF_FFFF);

        // reset asserted while the load request is on the bus
        reset_and_load(4);
        start_core("p4a");
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("p4_load_req",  32'(out_req_mem_access), 32'd1);
        check("p4_load_addr", out_addr, 32'h0000_0200);
        check("p4_load_type", 32'(out_data_inout_access_type), 32'd0);
        rst_n = 1'b0;
        #1;
        check("p4_req_dropped", 32'(out_req_mem_access), 32'd0);
        check("p4_addr_cleared", out_addr, 32'h0);
        repeat (2) @(negedge clk);
        start_core("p4b");
        run_to_halt("p4", 19);
        check("p4_r1_store",   rd32(32'h100), 32'h0000_0009);
        check("p4_no_branch",  rd32(32'h104), 32'h0000_0000);
        check("p4_reload",     rd32(32'h108), 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
